parking_exit_ctrl: RTL and testbench



---
 rtl/parking_pkg.sv | 30 +++
 rtl/parking_exit_ctrl_slot_timer.sv | 24 ++
 rtl/parking_exit_ctrl.sv | 165 ++++++++++++++++
 tb/tb_parking_exit_ctrl.sv | 291 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/parking_pkg.sv
// Shared constants and types for the parking lot exit controller and its slot timers.
package parking_pkg;

    localparam int SLOTS  = 8;
    localparam int SLOT_W = 3;
    localparam int TIME_W = 8;
    localparam int FEE_W  = 12;
    localparam int RATE   = 5;

    // Capacity vector encoding: a set bit means the slot is free.
    localparam logic SLOT_FREE  = 1'b1;
    localparam logic SLOT_TAKEN = 1'b0;

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_CHECK  = 2'd1;
    localparam logic [1:0] ST_CHARGE = 2'd2;
    localparam logic [1:0] ST_REPORT = 2'd3;

    typedef enum logic [1:0] {
        IDLE   = ST_IDLE,
        CHECK  = ST_CHECK,
        CHARGE = ST_CHARGE,
        REPORT = ST_REPORT
    } exit_state_e;

    function automatic int bit_width(input int value);
        return (value <= 0) ? 1 : $clog2(value + 1);
    endfunction

endpackage

// File: rtl/parking_exit_ctrl_slot_timer.sv
// Saturating occupancy timer for one parking slot; counts ticks only while the slot is occupied.
module slot_timer #(
    parameter int TIME_W = parking_pkg::TIME_W
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              tick,
    input  logic              occupied,
    input  logic              clear,
    output logic [TIME_W-1:0] count
);

    // Clear wins over tick so a slot entered or released on a tick edge starts from zero.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= '0;
        end else if (clear) begin
            count <= '0;
        end else if (tick && occupied && (count != '1)) begin
            count <= count + 1'b1;
        end
    end

endmodule

// File: rtl/parking_exit_ctrl.sv
// Exit-side parking controller: owns the capacity vector, applies entry grants,
// and validates, releases and prices exit requests through a valid/ready result port.
//
//   state  | meaning
//   IDLE   | ready for an exit request, slot latched on acceptance
//   CHECK  | latched slot inspected; free slot -> error report
//   CHARGE | fee computed from slot timer, slot released, timer cleared
//   REPORT | result held on done_* until accepted downstream
module parking_exit_ctrl #(
    parameter int SLOTS  = parking_pkg::SLOTS,
    parameter int TIME_W = parking_pkg::TIME_W,
    parameter int FEE_W  = parking_pkg::FEE_W,
    parameter int RATE   = parking_pkg::RATE
) (
    input  logic                           clk,
    input  logic                           rst_n,
    input  logic                           tick,
    input  logic                           entry_valid,
    input  logic [parking_pkg::SLOT_W-1:0] entry_slot,
    output logic                           entry_err,
    input  logic                           exit_req,
    input  logic [parking_pkg::SLOT_W-1:0] exit_slot,
    output logic                           exit_ready,
    output logic                           done_valid,
    input  logic                           done_ready,
    output logic [parking_pkg::SLOT_W-1:0] done_slot,
    output logic [FEE_W-1:0]               done_fee,
    output logic                           done_err,
    output logic [SLOTS-1:0]               parking_capacity,
    output logic [3:0]                     free_count,
    output logic                           lot_full
);

    import parking_pkg::*;

    localparam int RATE_W = bit_width(RATE);
    localparam int PROD_W = TIME_W + RATE_W;
    localparam int CMP_W  = (PROD_W > FEE_W) ? PROD_W : FEE_W;
    localparam logic [CMP_W-1:0] FEE_MAX = CMP_W'({FEE_W{1'b1}});

    exit_state_e       state;
    exit_state_e       state_nxt;
    logic [SLOT_W-1:0] slot_q;
    logic [TIME_W-1:0] timer [SLOTS];
    logic [SLOTS-1:0]  occupied;
    logic [SLOTS-1:0]  clear;
    logic              release_en;
    logic              entry_ok;
    logic              slot_q_free;
    logic [PROD_W-1:0] prod;
    logic [CMP_W-1:0]  prod_ext;
    logic [FEE_W-1:0]  fee_sat;

    assign release_en  = (state == CHARGE);
    assign entry_ok    = entry_valid && (parking_capacity[entry_slot] == SLOT_FREE);
    assign slot_q_free = (parking_capacity[slot_q] == SLOT_FREE);

    always_comb begin
        clear = '0;
        if (release_en) begin
            clear[slot_q] = 1'b1;
        end
        if (entry_ok) begin
            clear[entry_slot] = 1'b1;
        end
    end

    for (genvar i = 0; i < SLOTS; i++) begin : g_slot
        assign occupied[i] = (parking_capacity[i] != SLOT_FREE);

        slot_timer #(
            .TIME_W (TIME_W)
        ) u_timer (
            .clk      (clk),
            .rst_n    (rst_n),
            .tick     (tick),
            .occupied (occupied[i]),
            .clear    (clear[i]),
            .count    (timer[i])
        );
    end

    // Product is formed at full width so saturation sees the true value.
    assign prod     = PROD_W'(timer[slot_q]) * PROD_W'(RATE);
    assign prod_ext = CMP_W'(prod);
    assign fee_sat  = (prod_ext > FEE_MAX) ? '1 : prod_ext[FEE_W-1:0];

    // Release and entry can never target the same bit: release needs an occupied
    // slot, entry needs a free one, both judged on the current vector.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            parking_capacity <= {SLOTS{SLOT_FREE}};
        end else begin
            if (release_en) begin
                parking_capacity[slot_q] <= SLOT_FREE;
            end
            if (entry_ok) begin
                parking_capacity[entry_slot] <= SLOT_TAKEN;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            entry_err <= 1'b0;
        end else begin
            entry_err <= entry_valid && !entry_ok;
        end
    end

    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE:    if (exit_req) state_nxt = CHECK;
            CHECK:   state_nxt = slot_q_free ? REPORT : CHARGE;
            CHARGE:  state_nxt = REPORT;
            REPORT:  if (done_ready) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            slot_q    <= '0;
            done_slot <= '0;
            done_fee  <= '0;
            done_err  <= 1'b0;
        end else begin
            if (state == IDLE && exit_req) begin
                slot_q <= exit_slot;
            end
            if (state == CHECK && slot_q_free) begin
                done_slot <= slot_q;
                done_fee  <= '0;
                done_err  <= 1'b1;
            end
            if (state == CHARGE) begin
                done_slot <= slot_q;
                done_fee  <= fee_sat;
                done_err  <= 1'b0;
            end
        end
    end

    assign exit_ready = (state == IDLE);
    assign done_valid = (state == REPORT);

    always_comb begin
        free_count = '0;
        for (int i = 0; i < SLOTS; i++) begin
            free_count = free_count + 4'(parking_capacity[i] == SLOT_FREE);
        end
    end

    assign lot_full = (free_count == '0);

endmodule

// File: tb/tb_parking_exit_ctrl.sv
// Scoreboard bench for parking_exit_ctrl: a default-rate instance and a RATE=20 instance share stimulus.
module tb_parking_exit_ctrl;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        tick = 1'b0;
    logic        entry_valid = 1'b0;
    logic [2:0]  entry_slot = 3'd0;
    logic        exit_req = 1'b0;
    logic [2:0]  exit_slot = 3'd0;
    logic        done_ready = 1'b1;

    logic        entry_err, exit_ready, done_valid, done_err, lot_full;
    logic [2:0]  done_slot;
    logic [11:0] done_fee;
    logic [7:0]  parking_capacity;
    logic [3:0]  free_count;

    logic        entry_err_b, exit_ready_b, done_valid_b, done_err_b, lot_full_b;
    logic [2:0]  done_slot_b;
    logic [11:0] done_fee_b;
    logic [7:0]  parking_capacity_b;
    logic [3:0]  free_count_b;

    parking_exit_ctrl dut (
        .clk (clk), .rst_n (rst_n), .tick (tick),
        .entry_valid (entry_valid), .entry_slot (entry_slot), .entry_err (entry_err),
        .exit_req (exit_req), .exit_slot (exit_slot), .exit_ready (exit_ready),
        .done_valid (done_valid), .done_ready (done_ready), .done_slot (done_slot),
        .done_fee (done_fee), .done_err (done_err),
        .parking_capacity (parking_capacity), .free_count (free_count), .lot_full (lot_full)
    );

    parking_exit_ctrl #(.RATE(20)) dut_b (
        .clk (clk), .rst_n (rst_n), .tick (tick),
        .entry_valid (entry_valid), .entry_slot (entry_slot), .entry_err (entry_err_b),
        .exit_req (exit_req), .exit_slot (exit_slot), .exit_ready (exit_ready_b),
        .done_valid (done_valid_b), .done_ready (done_ready), .done_slot (done_slot_b),
        .done_fee (done_fee_b), .done_err (done_err_b),
        .parking_capacity (parking_capacity_b), .free_count (free_count_b), .lot_full (lot_full_b)
    );

    always #5 clk = ~clk;

    typedef struct {
        int slot;
        int fee;
        int fee_b;
        int err;
        int lat;
    } exp_t;

    exp_t sbq[$];
    int   n_cmp = 0;
    int   n_err = 0;
    int   ncyc = 0;
    int   acc_cyc = 0;
    logic dv_prev = 1'b0;

    task automatic check(input string tag, input int obs, input int exp);
        n_cmp++;
        if (obs != exp) begin
            n_err++;
            $display("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    function automatic int exp_fee(input int ticks, input int rate);
        int t;
        int p;
        t = (ticks > 255) ? 255 : ticks;
        p = t * rate;
        return (p > 4095) ? 4095 : p;
    endfunction

    // Negedge monitor: acceptance timestamp, first-valid latency, handshake pops.
    always @(negedge clk) begin
        exp_t e;
        ncyc++;
        if (exit_req && exit_ready) acc_cyc = ncyc;
        if (done_valid && !dv_prev && sbq.size() > 0)
            check("done_latency", ncyc - acc_cyc, sbq[0].lat);
        if (done_valid && done_ready) begin
            if (sbq.size() == 0) begin
                check("spurious_done", done_valid, 0);
            end else begin
                e = sbq.pop_front();
                check("done_slot", done_slot, e.slot);
                check("done_fee", done_fee, e.fee);
                check("done_err", done_err, e.err);
                check("done_fee_rate20", done_fee_b, e.fee_b);
                check("done_valid_rate20", done_valid_b, 1);
            end
        end
        dv_prev = done_valid;
    end

    task automatic check_reset();
        check("rst_capacity", parking_capacity, 255);
        check("rst_free_count", free_count, 8);
        check("rst_lot_full", lot_full, 0);
        check("rst_exit_ready", exit_ready, 1);
        check("rst_done_valid", done_valid, 0);
        check("rst_done_slot", done_slot, 0);
        check("rst_done_fee", done_fee, 0);
        check("rst_done_err", done_err, 0);
        check("rst_entry_err", entry_err, 0);
        check("rst_done_fee_rate20", done_fee_b, 0);
    endtask

    task automatic do_entry(input int s, input logic with_tick);
        entry_valid = 1'b1;
        entry_slot  = 3'(s);
        tick        = with_tick;
        @(posedge clk);
        #1 entry_valid = 1'b0;
        tick = 1'b0;
    endtask

    task automatic do_ticks(input int n);
        tick = 1'b1;
        repeat (n) @(posedge clk);
        #1 tick = 1'b0;
    endtask

    // mode 0: plain exit, 1: entry on slot es during CHARGE, 2: reset during CHARGE
    task automatic exit_start(input int s, input int mode, input int es, input int ee,
                              input int fee, input int fee_b, input int err);
        exp_t e;
        bit   ok;
        ok        = 1'b0;
        exit_req  = 1'b1;
        exit_slot = 3'(s);
        if (mode != 2) begin
            e.slot = s; e.fee = fee; e.fee_b = fee_b; e.err = err; e.lat = err ? 2 : 3;
            sbq.push_back(e);
        end
        for (int i = 0; i < 50 && !ok; i++) begin
            @(negedge clk);
            ok = exit_ready;
        end
        if (!ok) check("exit_accept", exit_ready, 1);
        @(posedge clk);
        #1 exit_req = 1'b0;
        if (mode == 1) begin
            @(posedge clk);
            #1 entry_valid = 1'b1;
            entry_slot = 3'(es);
            @(posedge clk);
            #1 entry_valid = 1'b0;
            @(negedge clk);
            check("entry_err_in_charge", entry_err, ee);
            @(posedge clk);
            #1;
        end else if (mode == 2) begin
            @(posedge clk);
            #1 check("busy_before_reset", exit_ready, 0);
            rst_n = 1'b0;
            @(negedge clk);
            check_reset();
            @(posedge clk);
            #1 rst_n = 1'b1;
        end
    endtask

    task automatic wait_done();
        for (int i = 0; i < 60 && sbq.size() > 0; i++) @(negedge clk);
        if (sbq.size() > 0) begin
            check("done_timeout", sbq.size(), 0);
            sbq.delete();
        end
        @(posedge clk);
        #1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        @(negedge clk);
        check_reset();
        @(posedge clk);
        #1;

        // Slot 7, three ticks
        do_entry(7, 1'b0);
        @(negedge clk);
        check("cap_after_entry7", parking_capacity, 8'h7F);
        check("free_after_entry7", free_count, 7);
        @(posedge clk);
        #1 do_ticks(3);
        exit_start(7, 0, 0, 0, exp_fee(3, 5), exp_fee(3, 20), 0);
        wait_done();
        check("cap_after_exit7", parking_capacity, 8'hFF);

        // Exit of a free slot is rejected
        exit_start(2, 0, 0, 0, 0, 0, 1);
        wait_done();
        check("cap_after_err_exit", parking_capacity, 8'hFF);

        // Entry coinciding with a tick leaves the timer at zero
        do_entry(5, 1'b1);
        exit_start(5, 0, 0, 0, 0, 0, 0);
        wait_done();

        // Timer and fee saturation
        do_entry(0, 1'b0);
        do_ticks(300);
        exit_start(0, 0, 0, 0, exp_fee(300, 5), exp_fee(300, 20), 0);
        wait_done();

        // Entry to the slot being released in CHARGE is refused
        do_entry(6, 1'b0);
        do_ticks(2);
        exit_start(6, 1, 6, 1, exp_fee(2, 5), exp_fee(2, 20), 0);
        wait_done();
        check("cap_after_same_slot", parking_capacity, 8'hFF);

        // Entry to another slot during CHARGE applies alongside the release
        do_entry(6, 1'b0);
        do_ticks(1);
        exit_start(6, 1, 1, 0, exp_fee(1, 5), exp_fee(1, 20), 0);
        wait_done();
        check("cap_after_cross_slot", parking_capacity, 8'hFD);
        check("free_after_cross_slot", free_count, 7);
        do_ticks(2);
        exit_start(1, 0, 0, 0, exp_fee(2, 5), exp_fee(2, 20), 0);
        wait_done();

        // Backpressure on the result port
        do_entry(4, 1'b0);
        do_ticks(4);
        done_ready = 1'b0;
        exit_start(4, 0, 0, 0, exp_fee(4, 5), exp_fee(4, 20), 0);
        for (int i = 0; i < 20 && !done_valid; i++) @(negedge clk);
        check("hold_reached_valid", done_valid, 1);
        @(posedge clk);
        #1 exit_req = 1'b1;
        exit_slot = 3'd1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("hold_valid", done_valid, 1);
            check("hold_slot", done_slot, 4);
            check("hold_fee", done_fee, exp_fee(4, 5));
            check("hold_err", done_err, 0);
            check("hold_exit_ready", exit_ready, 0);
        end
        @(posedge clk);
        #1 exit_req = 1'b0;
        done_ready = 1'b1;
        wait_done();
        repeat (4) @(negedge clk);
        check("idle_after_hold_valid", done_valid, 0);
        check("idle_after_hold_ready", exit_ready, 1);
        @(posedge clk);
        #1;

        // Fill the lot
        for (int s = 0; s < 8; s++) do_entry(s, 1'b0);
        @(negedge clk);
        check("full_lot_full", lot_full, 1);
        check("full_free_count", free_count, 0);
        check("full_capacity", parking_capacity, 0);
        @(posedge clk);
        #1 do_entry(3, 1'b0);
        @(negedge clk);
        check("full_entry_err", entry_err, 1);
        check("full_capacity_kept", parking_capacity, 0);
        @(negedge clk);
        check("entry_err_one_cycle", entry_err, 0);
        @(posedge clk);
        #1;

        // Reset during CHARGE discards the exit; slot 3 is free afterwards
        exit_start(3, 2, 0, 0, 0, 0, 0);
        @(negedge clk);
        check("post_reset_capacity", parking_capacity, 255);
        @(posedge clk);
        #1 exit_start(3, 0, 0, 0, 0, 0, 1);
        wait_done();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
